// File: rtl/dff_response_checker.sv
// Cycle-accurate checker for an enabled D flop with active-low preset: golden model, compare, counters.
// Optional first-failure capture (ff_vld/ff_idx/ff_exp) when CHK_FIRST_FAIL_CAPTURE_EN is defined.
module dff_response_checker #(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned NUM_SAMPLES  = 10,
   parameter logic        PRESET_VAL   = 1'b1,
   parameter bit          STOP_ON_FAIL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             obs_pre,
   input  logic             obs_d,
   input  logic             obs_e,
   input  logic             obs_q,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [CNT_W-1:0] cmp_cnt,
   output logic [CNT_W-1:0] err_cnt
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
   ,
   output logic             ff_vld,
   output logic [CNT_W-1:0] ff_idx,
   output logic             ff_exp
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             model_q;
   logic             model_vld;
   logic             model_q_d;
   logic             model_vld_d;
   logic [CNT_W-1:0] cmp_d;
   logic [CNT_W-1:0] err_d;
   logic             mis_d;
   logic             exp_now;
   logic             miss;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
   logic             ff_vld_d;
   logic [CNT_W-1:0] ff_idx_d;
   logic             ff_exp_d;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, golden-model update and compare
   always_comb begin
      state_d     = state_q;
      model_q_d   = model_q;
      model_vld_d = model_vld;
      cmp_d       = cmp_cnt;
      err_d       = err_cnt;
      mis_d       = 1'b0;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      ff_vld_d    = ff_vld;
      ff_idx_d    = ff_idx;
      ff_exp_d    = ff_exp;
`endif
      // Preset is asynchronous on the real flop, so it overrides the registered model.
      exp_now = (!obs_pre) ? PRESET_VAL : model_q;
      miss    = (obs_q !== exp_now);

      if ((state_q == S_ARM) || (state_q == S_RUN)) begin
         if (!obs_pre) begin
            model_q_d   = PRESET_VAL;
            model_vld_d = 1'b1;
         end else if (obs_e) begin
            model_q_d   = obs_d;
            model_vld_d = 1'b1;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_ARM;
               cmp_d       = '0;
               err_d       = '0;
               model_vld_d = 1'b0;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
               ff_vld_d    = 1'b0;
               ff_idx_d    = '0;
               ff_exp_d    = 1'b0;
`endif
            end
         end
         S_ARM: begin
            if (model_vld) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (model_vld) begin
               cmp_d = cmp_cnt + CNT_W'(1);
               if (miss) begin
                  mis_d = 1'b1;
                  if (err_cnt != CNT_MAX) begin
                     err_d = err_cnt + CNT_W'(1);
                  end
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
                  if (!ff_vld) begin
                     ff_vld_d = 1'b1;
                     ff_idx_d = cmp_cnt;
                     ff_exp_d = exp_now;
                  end
`endif
               end
               if ((cmp_d == CNT_LAST) || (STOP_ON_FAIL && miss)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // Model validity is kept so a restart can skip straight through ARM.
            if (start) begin
               state_d  = S_ARM;
               cmp_d    = '0;
               err_d    = '0;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
               ff_vld_d = 1'b0;
               ff_idx_d = '0;
               ff_exp_d = 1'b0;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Model, counters and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         model_q   <= 1'b0;
         model_vld <= 1'b0;
         cmp_cnt   <= '0;
         err_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         mismatch  <= 1'b0;
      end else begin
         model_q   <= model_q_d;
         model_vld <= model_vld_d;
         cmp_cnt   <= cmp_d;
         err_cnt   <= err_d;
         busy      <= (state_d == S_ARM) || (state_d == S_RUN);
         done      <= (state_d == S_DONE);
         pass      <= (state_d == S_DONE) && (err_d == '0);
         mismatch  <= mis_d;
      end
   end

`ifdef CHK_FIRST_FAIL_CAPTURE_EN
   // First-failure capture, held until reset or the next start
   always_ff @(posedge clk) begin
      if (rst) begin
         ff_vld <= 1'b0;
         ff_idx <= '0;
         ff_exp <= 1'b0;
      end else begin
         ff_vld <= ff_vld_d;
         ff_idx <= ff_idx_d;
         ff_exp <= ff_exp_d;
      end
   end
`endif

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: a reference flop drives obs_q, a run-level model predicts every output.
// Two instances share stimulus: STOP_ON_FAIL=0 (u_dut) and STOP_ON_FAIL=1 (u_stop).
module tb_dff_response_checker;

   localparam int unsigned CNT_W = 16;
   localparam int          NUM   = 10;
   localparam int          BUDGET = 40;

   logic clk = 1'b0;
   logic rst, start, obs_pre, obs_d, obs_e, obs_q;
   logic busy0, done0, pass0, mis0, busy1, done1, pass1, mis1;
   logic [CNT_W-1:0] cmp0, err0, cmp1, err1;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
   logic ffv0, ffe0, ffv1, ffe1;
   logic [CNT_W-1:0] ffi0, ffi1;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state, index 0 = u_dut, 1 = u_stop
   int m_ph [2];   // 0 idle, 1 arm, 2 run, 3 done
   bit m_vld [2];
   int m_cmp [2];
   int m_err [2];
   bit m_mis [2];
   bit m_ffv [2];
   int m_ffi [2];
   bit m_ffe [2];
   bit flop;

   always #5 clk = ~clk;

   dff_response_checker #(.CNT_W(CNT_W), .NUM_SAMPLES(NUM), .PRESET_VAL(1'b1), .STOP_ON_FAIL(1'b0)) u_dut (
      .clk(clk), .rst(rst), .start(start), .obs_pre(obs_pre), .obs_d(obs_d), .obs_e(obs_e), .obs_q(obs_q),
      .busy(busy0), .done(done0), .pass(pass0), .mismatch(mis0), .cmp_cnt(cmp0), .err_cnt(err0)
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      , .ff_vld(ffv0), .ff_idx(ffi0), .ff_exp(ffe0)
`endif
   );

   dff_response_checker #(.CNT_W(CNT_W), .NUM_SAMPLES(NUM), .PRESET_VAL(1'b1), .STOP_ON_FAIL(1'b1)) u_stop (
      .clk(clk), .rst(rst), .start(start), .obs_pre(obs_pre), .obs_d(obs_d), .obs_e(obs_e), .obs_q(obs_q),
      .busy(busy1), .done(done1), .pass(pass1), .mismatch(mis1), .cmp_cnt(cmp1), .err_cnt(err1)
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      , .ff_vld(ffv1), .ff_idx(ffi1), .ff_exp(ffe1)
`endif
   );

   // One clock: advance the reference flop and the checker model, then return at the falling edge
   task automatic step();
      bit truth;
      bit miss;
      @(posedge clk);
      truth = obs_pre ? flop : 1'b1;
      miss  = (obs_q !== truth);
      for (int s = 0; s < 2; s++) begin
         int ph;
         ph = m_ph[s];
         m_mis[s] = 1'b0;
         if (rst) begin
            m_ph[s] = 0; m_vld[s] = 1'b0; m_cmp[s] = 0; m_err[s] = 0;
            m_ffv[s] = 1'b0; m_ffi[s] = 0; m_ffe[s] = 1'b0;
         end else begin
            case (ph)
               0, 3: if (start) begin
                  m_ph[s] = 1; m_cmp[s] = 0; m_err[s] = 0;
                  m_ffv[s] = 1'b0; m_ffi[s] = 0; m_ffe[s] = 1'b0;
                  if (ph == 0) m_vld[s] = 1'b0;
               end
               1: if (m_vld[s]) m_ph[s] = 2;
               2: begin
                  if (miss) begin
                     m_mis[s] = 1'b1;
                     if (m_err[s] < 65535) m_err[s] = m_err[s] + 1;
                     if (!m_ffv[s]) begin
                        m_ffv[s] = 1'b1; m_ffi[s] = m_cmp[s]; m_ffe[s] = truth;
                     end
                  end
                  m_cmp[s] = m_cmp[s] + 1;
                  if (m_cmp[s] == NUM || (s == 1 && miss)) m_ph[s] = 3;
               end
               default: ;
            endcase
            if ((ph == 1 || ph == 2) && (!obs_pre || obs_e)) m_vld[s] = 1'b1;
         end
      end
      flop = !obs_pre ? 1'b1 : (obs_e ? obs_d : flop);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      obs_pre = 1'b1; obs_e = 1'b0; obs_d = 1'b0; obs_q = flop;
   endtask

   task automatic kick();
      idle_inputs();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Random flop traffic until u_dut finishes (or a compare count is reached); tallies disagreements
   task automatic run(input int fault_at, input int pre_at, input int stop_at,
                      output int cyc, output int bad, output int pulses);
      bit p, dd, ee;
      cyc = 0; bad = 0; pulses = 0;
      while (cyc < BUDGET && m_ph[0] != 3 && !(stop_at >= 0 && m_ph[0] == 2 && m_cmp[0] == stop_at)) begin
         p  = (cyc == 0) ? 1'b0 : ($urandom_range(0, 5) != 0);
         dd = 1'($urandom);
         ee = 1'($urandom);
         if (m_ph[0] == 2 && m_cmp[0] == pre_at) begin p = 1'b0; dd = 1'b0; ee = 1'b1; end
         obs_pre = p; obs_d = dd; obs_e = ee;
         obs_q = p ? flop : 1'b1;
         if (m_ph[0] == 2 && m_cmp[0] == fault_at) obs_q = ~obs_q;
         step();
         cyc++;
         pulses += int'(mis0);
         if (busy0 !== (m_ph[0] == 1 || m_ph[0] == 2) || done0 !== (m_ph[0] == 3) ||
             pass0 !== (m_ph[0] == 3 && m_err[0] == 0) || mis0 !== m_mis[0] ||
             cmp0 !== CNT_W'(m_cmp[0]) || err0 !== CNT_W'(m_err[0])) bad++;
         if (busy1 !== (m_ph[1] == 1 || m_ph[1] == 2) || done1 !== (m_ph[1] == 3) ||
             pass1 !== (m_ph[1] == 3 && m_err[1] == 0) || mis1 !== m_mis[1] ||
             cmp1 !== CNT_W'(m_cmp[1]) || err1 !== CNT_W'(m_err[1])) bad++;
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; idle_inputs();
      step(); step();
      n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
      n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done0); end
      n_cmp++; if (pass0 !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %b want 0", pass0); end
      n_cmp++; if (mis0 !== 1'b0) begin n_bad++; $display("FAIL reset_mismatch: got %b want 0", mis0); end
      n_cmp++; if (cmp0 !== '0 || err0 !== '0) begin n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cmp0, err0); end
      n_cmp++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin n_bad++; $display("FAIL reset_stop_inst: got busy %b done %b want 0 0", busy1, done1); end
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      n_cmp++; if (ffv0 !== 1'b0 || ffi0 !== '0 || ffe0 !== 1'b0) begin n_bad++; $display("FAIL reset_ff: got %b %0d %b want 0 0 0", ffv0, ffi0, ffe0); end
`endif
      rst = 1'b0;
      step();
   endtask

   task automatic test_clean_run();
      int cyc, bad, pulses;
      kick();
      run(-1, -1, -1, cyc, bad, pulses);
      n_cmp++; if (cyc >= BUDGET) begin n_bad++; $display("FAIL clean_timeout: got %0d cycles want < %0d", cyc, BUDGET); end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clean_trace: got %0d bad cycles want 0", bad); end
      n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL clean_pulses: got %0d want 0", pulses); end
      n_cmp++; if (cmp0 !== 16'd10 || err0 !== 16'd0) begin n_bad++; $display("FAIL clean_counts: got %0d/%0d want 10/0", cmp0, err0); end
      n_cmp++; if (done0 !== 1'b1 || pass0 !== 1'b1 || busy0 !== 1'b0) begin n_bad++; $display("FAIL clean_status: got d%b p%b b%b want 1 1 0", done0, pass0, busy0); end
      n_cmp++; if (cmp1 !== 16'd10 || pass1 !== 1'b1) begin n_bad++; $display("FAIL clean_stop_inst: got %0d p%b want 10 1", cmp1, pass1); end
      step();
      n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL clean_done_held: got %b want 1", done0); end
   endtask

   task automatic test_fault();
      int cyc, bad, pulses;
      kick();
      run(3, -1, -1, cyc, bad, pulses);
      n_cmp++; if (bad != 0 || cyc >= BUDGET) begin n_bad++; $display("FAIL fault_trace: got %0d bad, %0d cycles want 0", bad, cyc); end
      n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL fault_pulses: got %0d want 1", pulses); end
      n_cmp++; if (err0 !== 16'd1 || cmp0 !== 16'd10 || pass0 !== 1'b0) begin n_bad++; $display("FAIL fault_result: got %0d/%0d p%b want 10/1 p0", cmp0, err0, pass0); end
      n_cmp++; if (cmp1 !== 16'd4 || err1 !== 16'd1 || done1 !== 1'b1) begin n_bad++; $display("FAIL fault_stop_inst: got %0d/%0d d%b want 4/1 d1", cmp1, err1, done1); end
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      n_cmp++; if (ffv0 !== 1'b1 || ffi0 !== 16'd3 || ffe0 !== m_ffe[0]) begin n_bad++; $display("FAIL fault_ff: got %b %0d %b want 1 3 %b", ffv0, ffi0, ffe0, m_ffe[0]); end
`endif
   endtask

   task automatic test_stop_on_fail();
      int cyc, bad, pulses;
      kick();
      run(2, -1, -1, cyc, bad, pulses);
      n_cmp++; if (bad != 0 || cyc >= BUDGET) begin n_bad++; $display("FAIL stop_trace: got %0d bad, %0d cycles want 0", bad, cyc); end
      n_cmp++; if (cmp1 !== 16'd3 || err1 !== 16'd1) begin n_bad++; $display("FAIL stop_counts: got %0d/%0d want 3/1", cmp1, err1); end
      n_cmp++; if (done1 !== 1'b1 || pass1 !== 1'b0) begin n_bad++; $display("FAIL stop_status: got d%b p%b want 1 0", done1, pass1); end
   endtask

   task automatic test_preset_override();
      int cyc, bad, pulses;
      kick();
      run(-1, 2, -1, cyc, bad, pulses);
      n_cmp++; if (bad != 0 || err0 !== 16'd0 || pulses != 0) begin n_bad++; $display("FAIL preset_match: got %0d bad, err %0d want 0 0", bad, err0); end
      kick();
      run(2, 2, -1, cyc, bad, pulses);
      n_cmp++; if (bad != 0 || err0 !== 16'd1 || pulses != 1) begin n_bad++; $display("FAIL preset_miss: got %0d bad, err %0d, %0d pulses want 0 1 1", bad, err0, pulses); end
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
      n_cmp++; if (ffe0 !== 1'b1 || ffi0 !== 16'd2) begin n_bad++; $display("FAIL preset_ff: got exp %b idx %0d want 1 2", ffe0, ffi0); end
`endif
   endtask

   task automatic test_reset_mid_run();
      int cyc, bad, pulses;
      kick();
      run(-1, -1, 5, cyc, bad, pulses);
      n_cmp++; if (cmp0 !== 16'd5 || busy0 !== 1'b1 || bad != 0) begin n_bad++; $display("FAIL midrun_pre: got %0d b%b bad %0d want 5 1 0", cmp0, busy0, bad); end
      rst = 1'b1; start = 1'b1;
      step();
      rst = 1'b0; start = 1'b0;
      step();
      n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0 || mis0 !== 1'b0) begin n_bad++; $display("FAIL midrun_status: got b%b d%b m%b want 0 0 0", busy0, done0, mis0); end
      n_cmp++; if (cmp0 !== '0 || err0 !== '0 || cmp1 !== '0) begin n_bad++; $display("FAIL midrun_counters: got %0d/%0d/%0d want 0", cmp0, err0, cmp1); end
      kick();
      run(-1, -1, -1, cyc, bad, pulses);
      n_cmp++; if (bad != 0 || cmp0 !== 16'd10 || pass0 !== 1'b1 || cyc >= BUDGET) begin n_bad++; $display("FAIL midrun_rerun: got %0d bad, cmp %0d p%b want 0 10 1", bad, cmp0, pass0); end
   endtask

   task automatic test_back_to_back();
      int cyc, bad, pulses, k;
      for (int i = 0; i < 4; i++) begin
         k = $urandom_range(0, NUM - 1);
         kick();
         run(k, -1, -1, cyc, bad, pulses);
         n_cmp++; if (bad != 0 || err0 !== 16'd1 || cmp1 !== CNT_W'(k + 1)) begin n_bad++; $display("FAIL b2b_%0d: got %0d bad, err %0d, stop cmp %0d want 0 1 %0d", i, bad, err0, cmp1, k + 1); end
      end
   endtask

   initial begin
      flop = 1'b1;
      for (int s = 0; s < 2; s++) begin
         m_ph[s] = 0; m_vld[s] = 1'b0; m_cmp[s] = 0; m_err[s] = 0; m_mis[s] = 1'b0;
         m_ffv[s] = 1'b0; m_ffi[s] = 0; m_ffe[s] = 1'b0;
      end
      rst = 1'b1; start = 1'b0; idle_inputs();
      @(negedge clk);
      test_reset();
      test_clean_run();
      test_fault();
      test_stop_on_fail();
      test_preset_override();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
